vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SW, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SW, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- COL_W, 3, bits per colour channel
- LAT, 2, pixel-source read latency in clocks (0..7)

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- en  in  1  advance timing; low freezes all counters and pipeline
- px_r/px_g/px_b  in  COL_W each  pixel data, valid LAT clocks after matching hcount/vcount
- hcount  out  11  fetch column, leads output by LAT+1
- vcount  out  10  fetch line, leads output by LAT+1
- red/green/blue  out  COL_W each  registered colour, zero outside visible area
- hsync/vsync  out  1  registered syncs at HS_POL/VS_POL when active
- blank  out  1  outside visible area, aligned with colour
- vblank  out  1  line >= V_VIS, aligned with colour
- line_start  out  1  one-clock pulse on the first output pixel of every line
- frame_start  out  1  one-clock pulse on output pixel (0,0)

Function
REQ-003 H_TOT = H_VIS+H_FP+H_SW+H_BP; V_TOT analogous; both computed as localparams.
REQ-004 hcount SHALL count 0..H_TOT-1 while en=1 and wrap to 0; vcount SHALL increment when hcount wraps and wrap to 0 after V_TOT-1.
REQ-005 Each axis SHALL run a 4-state FSM VIS->FP->SYNC->BP->VIS, with transitions at the counter boundaries H_VIS, H_VIS+H_FP, H_VIS+H_FP+H_SW, and 0.
REQ-006 The vertical FSM SHALL change state only on the horizontal wrap.
REQ-007 Per-axis state and visible flags SHALL be delayed through a LAT+1 stage shift register, so that sync, blank, vblank and colour at the outputs all refer to the same pixel.
REQ-008 Colour outputs SHALL register px_* when the delayed position is visible, else 0.
REQ-009 hsync SHALL be active exactly H_SW clocks per line; vsync SHALL be active exactly V_SW*H_TOT clocks per frame.
REQ-010 With en=0, counters, FSMs and the delay line SHALL hold; outputs SHALL hold their last values.
REQ-011 frame_start SHALL imply line_start in the same clock.

Reset
REQ-012 On reset: hcount=0, vcount=0, FSMs=VIS, delay line cleared to blank.
REQ-013 On reset, outputs SHALL be: colour 0, hsync=!HS_POL, vsync=!VS_POL, blank=1, vblank=0, pulses 0.
REQ-014 Reset SHALL override en, and reset mid-frame SHALL restart at (0,0) on the next clock.
REQ-015 frame_start SHALL first assert LAT+1 clocks after reset release with en=1.

Configuration
REQ-016 Macro VGA_TIMING_GEN_PATTERN_EN SHALL control the built-in test pattern.
- Defined: add input pat_sel (1 bit); when pat_sel=1, colour SHALL be 8 vertical bars of width H_VIS/8, bar index b mapping to red=b[0], green=b[1], blue=b[2] replicated to COL_W, and px_* SHALL be ignored.
- Undefined: no pat_sel port; colour always comes from px_*.

Structure
REQ-017 Package vga_pkg SHALL hold the FSM state enum (VIS, FP, SYNC, BP) and the default 640x480@60 timing constants.
REQ-018 Sub-module vga_axis_fsm (counter + 4-state FSM, parametrised by segment lengths) SHALL be instantiated twice, for horizontal and vertical.

Verification
REQ-019 Default params, en=1 for 2 frames: hsync low for 96 clocks starting at output column 656; line period 800 clocks; frame period 420000 clocks.
REQ-020 LAT=2, px_r driven = hcount[2:0] delayed 2 clocks: red at visible output column N equals N[2:0]; columns 640..799 give red=0, blank=1.
REQ-021 HS_POL=1, VS_POL=1: vsync high for exactly 1600 clocks, starting at output line 490 column 0.
REQ-022 en toggled 0 for 37 clocks mid-line: all outputs constant during the gap; line period measured in en=1 clocks remains 800.
REQ-023 Reset asserted at hcount=300, vcount=200: next clock hcount=0, vcount=0; frame_start fires LAT+1 clocks after release.
REQ-024 PATTERN_EN defined, pat_sel=1: output column 0 colour (0,0,0); column 80 red all-ones; column 560 (7,7,7).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared segment enum, per-pixel pipeline record and default 640x480@60 timing
// for the VGA timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        VIS  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } seg_t;

    localparam int unsigned DEF_H_VIS = 640;
    localparam int unsigned DEF_H_FP  = 16;
    localparam int unsigned DEF_H_SW  = 96;
    localparam int unsigned DEF_H_BP  = 48;
    localparam int unsigned DEF_V_VIS = 480;
    localparam int unsigned DEF_V_FP  = 10;
    localparam int unsigned DEF_V_SW  = 2;
    localparam int unsigned DEF_V_BP  = 33;

    typedef struct packed {
        seg_t h_seg;
        seg_t v_seg;
        logic h_first;
        logic v_first;
    } pix_info_t;

    // Horizontal blanking with vertical VIS: blank, no sync, vblank low.
    localparam pix_info_t PIX_BLANK = '{h_seg: FP, v_seg: VIS, h_first: 1'b0, v_first: 1'b0};

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: position counter plus its VIS->FP->SYNC->BP segment FSM.
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int unsigned VIS_LEN = DEF_H_VIS,
    parameter int unsigned FP_LEN  = DEF_H_FP,
    parameter int unsigned SW_LEN  = DEF_H_SW,
    parameter int unsigned BP_LEN  = DEF_H_BP,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       seg
);

    localparam int unsigned      TOT   = VIS_LEN + FP_LEN + SW_LEN + BP_LEN;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOT - 1);
    localparam logic [CNT_W-1:0] FP_AT = CNT_W'(VIS_LEN);
    localparam logic [CNT_W-1:0] SW_AT = CNT_W'(VIS_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] BP_AT = CNT_W'(VIS_LEN + FP_LEN + SW_LEN);

    seg_t             state, state_nx;
    logic [CNT_W-1:0] count_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= VIS;
        end else if (en) begin
            count <= count_nx;
            state <= state_nx;
        end
    end

    // Decoding the next count keeps segment and position changing on the same edge.
    always_comb begin
        count_nx = (count == LAST) ? '0 : count + 1'b1;
        state_nx = state;
        case (state)
            VIS:  if (count_nx == FP_AT) state_nx = FP;
            FP:   if (count_nx == SW_AT) state_nx = SYNC;
            SYNC: if (count_nx == BP_AT) state_nx = BP;
            BP:   if (count_nx == '0)    state_nx = VIS;
        endcase
    end

    assign seg = state;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/colour generator; fetch position leads the outputs by LAT+1 clocks.
// Define VGA_TIMING_GEN_PATTERN_EN to add pat_sel and the 8-bar test pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = DEF_H_VIS,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SW   = DEF_H_SW,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_VIS  = DEF_V_VIS,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SW   = DEF_V_SW,
    parameter int unsigned V_BP   = DEF_V_BP,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    parameter int unsigned COL_W  = 3,
    parameter int unsigned LAT    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
`ifdef VGA_TIMING_GEN_PATTERN_EN
    input  logic             pat_sel,
`endif
    input  logic [COL_W-1:0] px_r,
    input  logic [COL_W-1:0] px_g,
    input  logic [COL_W-1:0] px_b,
    output logic [10:0]      hcount,
    output logic [9:0]       vcount,
    output logic [COL_W-1:0] red,
    output logic [COL_W-1:0] green,
    output logic [COL_W-1:0] blue,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             vblank,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SW + H_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);

`ifdef VGA_TIMING_GEN_PATTERN_EN
    localparam int unsigned BAR_W = H_VIS / 8;
    typedef struct packed {
        pix_info_t  pix;
        logic [2:0] bar;
    } stage_t;
    localparam stage_t STAGE_BLANK = '{pix: PIX_BLANK, bar: 3'd0};
`else
    typedef struct packed {
        pix_info_t pix;
    } stage_t;
    localparam stage_t STAGE_BLANK = '{pix: PIX_BLANK};
`endif

    logic [1:0]       h_seg_raw, v_seg_raw;
    logic             h_wrap;
    stage_t           cur, tap;
    logic             visible;
    logic [COL_W-1:0] col_r, col_g, col_b;

    assign h_wrap = (hcount == H_LAST);

    vga_axis_fsm #(
        .VIS_LEN(H_VIS),
        .FP_LEN (H_FP),
        .SW_LEN (H_SW),
        .BP_LEN (H_BP),
        .CNT_W  (11)
    ) u_h_axis (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .count(hcount),
        .seg  (h_seg_raw)
    );

    vga_axis_fsm #(
        .VIS_LEN(V_VIS),
        .FP_LEN (V_FP),
        .SW_LEN (V_SW),
        .BP_LEN (V_BP),
        .CNT_W  (10)
    ) u_v_axis (
        .clk  (clk),
        .reset(reset),
        .en   (en & h_wrap),
        .count(vcount),
        .seg  (v_seg_raw)
    );

    always_comb begin
        cur             = '0;
        cur.pix.h_seg   = seg_t'(h_seg_raw);
        cur.pix.v_seg   = seg_t'(v_seg_raw);
        cur.pix.h_first = (hcount == '0);
        cur.pix.v_first = (vcount == '0);
`ifdef VGA_TIMING_GEN_PATTERN_EN
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(hcount) >= k * BAR_W) cur.bar = 3'(k);
        end
`endif
    end

    // LAT stages here plus the output register give the LAT+1 alignment with px_*.
    if (LAT == 0) begin : g_no_dly
        assign tap = cur;
    end else begin : g_dly
        stage_t dly [LAT];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < LAT; i++) dly[i] <= STAGE_BLANK;
            end else if (en) begin
                dly[0] <= cur;
                for (int unsigned i = 1; i < LAT; i++) dly[i] <= dly[i-1];
            end
        end

        assign tap = dly[LAT-1];
    end

    always_comb begin
        visible = (tap.pix.h_seg == VIS) && (tap.pix.v_seg == VIS);
        col_r   = px_r;
        col_g   = px_g;
        col_b   = px_b;
`ifdef VGA_TIMING_GEN_PATTERN_EN
        if (pat_sel) begin
            col_r = {COL_W{tap.bar[0]}};
            col_g = {COL_W{tap.bar[1]}};
            col_b = {COL_W{tap.bar[2]}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= !HS_POL;
            vsync       <= !VS_POL;
            blank       <= 1'b1;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            red         <= visible ? col_r : '0;
            green       <= visible ? col_g : '0;
            blue        <= visible ? col_b : '0;
            hsync       <= (tap.pix.h_seg == SYNC) ? HS_POL : !HS_POL;
            vsync       <= (tap.pix.v_seg == SYNC) ? VS_POL : !VS_POL;
            blank       <= !visible;
            vblank      <= (tap.pix.v_seg != VIS);
            line_start  <= tap.pix.h_first;
            frame_start <= tap.pix.h_first & tap.pix.v_first;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing, shortened frame
// (4/2/2/3 lines) so whole frames fit; a second instance covers LAT=0 and positive syncs.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  px_r, px_g, px_b;
    logic [2:0]  zero3 = 3'd0;
`ifdef VGA_TIMING_GEN_PATTERN_EN
    logic        pat_sel = 1'b0;
`endif

    logic [10:0] hcount, hcount2;
    logic [9:0]  vcount, vcount2;
    logic [2:0]  red, green, blue, red2, green2, blue2;
    logic        hsync, vsync, blank, vblank, line_start, frame_start;
    logic        hsync2, vsync2, blank2, vblank2, line_start2, frame_start2;

    logic [2:0]  pr_d1, pr_d2, pg_d1, pg_d2;
    logic [35:0] obs;

    int errors = 0;
    int checks = 0;
    int n = 0;
    bit track_on = 1'b0;
    int last_ls = -1, ls_min = 1000000000, ls_max = 0;
    int last_fs = -1, fs_period = -1;
    int hs1_low = 0, hs2_high = 0, vs2_high = 0, vs2_first = -1;

    typedef struct {
        int line; int col;
        int hs; int vs; int bl; int vb;
        int r; int g; int b;
        int ls; int fs;
    } vec_t;

    always #5 clk = ~clk;

    // Pixel source with a 2-clock read latency: r = column[2:0], g = line[2:0], b = ~r.
    always @(posedge clk) begin
        if (en) begin
            pr_d1 <= hcount[2:0];
            pr_d2 <= pr_d1;
            pg_d1 <= vcount[2:0];
            pg_d2 <= pg_d1;
        end
    end
    assign px_r = pr_d2;
    assign px_g = pg_d2;
    assign px_b = ~pr_d2;

    assign obs = {hcount, vcount, red, green, blue, hsync, vsync, blank, vblank,
                  line_start, frame_start};

    vga_timing_gen #(
        .V_VIS(4), .V_FP(2), .V_SW(2), .V_BP(3), .LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
`ifdef VGA_TIMING_GEN_PATTERN_EN
        .pat_sel(pat_sel),
`endif
        .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .hcount(hcount), .vcount(vcount),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blank(blank), .vblank(vblank),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_gen #(
        .V_VIS(4), .V_FP(2), .V_SW(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .LAT(0)
    ) dut2 (
        .clk(clk), .reset(reset), .en(en),
`ifdef VGA_TIMING_GEN_PATTERN_EN
        .pat_sel(pat_sel),
`endif
        .px_r(zero3), .px_g(zero3), .px_b(zero3),
        .hcount(hcount2), .vcount(vcount2),
        .red(red2), .green(green2), .blue(blue2),
        .hsync(hsync2), .vsync(vsync2), .blank(blank2), .vblank(vblank2),
        .line_start(line_start2), .frame_start(frame_start2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One enabled clock; n counts clocks since reset release, outputs sampled on negedge.
    task automatic step();
        int idx1, idx2;
        @(negedge clk);
        if (en && !reset) n++;
        if (track_on) begin
            idx1 = n - 3;
            idx2 = n - 1;
            if (line_start) begin
                if (last_ls >= 0) begin
                    if (n - last_ls < ls_min) ls_min = n - last_ls;
                    if (n - last_ls > ls_max) ls_max = n - last_ls;
                end
                last_ls = n;
            end
            if (frame_start) begin
                if (last_fs >= 0) fs_period = n - last_fs;
                last_fs = n;
            end
            if (idx1 >= 0 && idx1 < 800 && !hsync) hs1_low++;
            if (idx2 >= 0 && idx2 < 800 && hsync2) hs2_high++;
            if (idx2 >= 0 && idx2 < 8800 && vsync2) begin
                vs2_high++;
                if (vs2_first < 0) vs2_first = idx2;
            end
        end
    endtask

    initial begin
        vec_t        tbl [20];
        int          first1, first2, changes, tgt;
        logic [35:0] snap;
        bit          found;

        tbl[0]  = '{0,   0,   1, 1, 0, 0, 0, 0, 7, 1, 1};
        tbl[1]  = '{0,   5,   1, 1, 0, 0, 5, 0, 2, 0, 0};
        tbl[2]  = '{0,   639, 1, 1, 0, 0, 7, 0, 0, 0, 0};
        tbl[3]  = '{0,   640, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0,   655, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0,   656, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0,   751, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0,   752, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0,   799, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1,   0,   1, 1, 0, 0, 0, 1, 7, 1, 0};
        tbl[10] = '{1,   13,  1, 1, 0, 0, 5, 1, 2, 0, 0};
        tbl[11] = '{3,   100, 1, 1, 0, 0, 4, 3, 3, 0, 0};
        tbl[12] = '{3,   700, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{4,   0,   1, 1, 1, 1, 0, 0, 0, 1, 0};
        tbl[14] = '{5,   799, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[15] = '{6,   0,   1, 0, 1, 1, 0, 0, 0, 1, 0};
        tbl[16] = '{7,   799, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[17] = '{8,   0,   1, 1, 1, 1, 0, 0, 0, 1, 0};
        tbl[18] = '{10,  799, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[19] = '{11,  0,   1, 1, 0, 0, 0, 0, 7, 1, 1};

        reset = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst.hcount", hcount, 0);
        chk("rst.vcount", vcount, 0);
        chk("rst.rgb", {red, green, blue}, 0);
        chk("rst.hsync", hsync, 1);
        chk("rst.vsync", vsync, 1);
        chk("rst.blank", blank, 1);
        chk("rst.vblank", vblank, 0);
        chk("rst.pulses", {line_start, frame_start}, 0);
        chk("rst.hsync_pos", hsync2, 0);
        chk("rst.vsync_pos", vsync2, 0);

        reset    = 1'b0;
        n        = 0;
        track_on = 1'b1;
        first1   = -1;
        first2   = -1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (frame_start && first1 < 0) first1 = n;
            if (frame_start2 && first2 < 0) first2 = n;
        end
        chk("fs_latency_lat2", first1, 3);
        chk("fs_latency_lat0", first2, 1);

        for (int i = 0; i < 20; i++) begin
            tgt = tbl[i].line * 800 + tbl[i].col + 3;
            while (n < tgt) step();
            chk($sformatf("v%0d.hsync", i), hsync, tbl[i].hs);
            chk($sformatf("v%0d.vsync", i), vsync, tbl[i].vs);
            chk($sformatf("v%0d.blank", i), blank, tbl[i].bl);
            chk($sformatf("v%0d.vblank", i), vblank, tbl[i].vb);
            chk($sformatf("v%0d.red", i), red, tbl[i].r);
            chk($sformatf("v%0d.green", i), green, tbl[i].g);
            chk($sformatf("v%0d.blue", i), blue, tbl[i].b);
            chk($sformatf("v%0d.line_start", i), line_start, tbl[i].ls);
            chk($sformatf("v%0d.frame_start", i), frame_start, tbl[i].fs);
        end

        // en low for 37 clocks at output (line 11, column 300): everything must freeze.
        while (n < 11 * 800 + 300 + 3) step();
        snap    = obs;
        changes = 0;
        en      = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            if (obs !== snap) changes++;
        end
        chk("gap.changes", changes, 0);
        chk("gap.hcount", hcount, 303);
        en = 1'b1;
        step();
        chk("gap.after_red", red, 5);
        chk("gap.after_green", green, 0);
        chk("gap.after_blue", blue, 2);
        chk("gap.after_blank", blank, 0);
        while (n < 12 * 800 + 3) step();
        chk("gap.line_start", line_start, 1);

        chk("line_period_min", ls_min, 800);
        chk("line_period_max", ls_max, 800);
        chk("frame_period", fs_period, 8800);
        chk("hsync_low_clocks", hs1_low, 96);
        chk("hsync_pos_high_clocks", hs2_high, 96);
        chk("vsync_pos_high_clocks", vs2_high, 1600);
        chk("vsync_pos_first_index", vs2_first, 6 * 800);

        // Mid-frame reset at fetch position (300, 9).
        track_on = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (hcount == 11'd300 && vcount == 10'd9) found = 1'b1;
            else step();
        end
        chk("reach_300_9", found, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.hcount", hcount, 0);
        chk("midrst.vcount", vcount, 0);
        chk("midrst.blank", blank, 1);
        chk("midrst.frame_start", frame_start, 0);
`ifdef VGA_TIMING_GEN_PATTERN_EN
        pat_sel = 1'b1;
`endif
        reset  = 1'b0;
        n      = 0;
        first1 = -1;
        for (int i = 0; i < 8 && first1 < 0; i++) begin
            step();
            if (frame_start) first1 = n;
        end
        chk("midrst.fs_latency", first1, 3);

`ifdef VGA_TIMING_GEN_PATTERN_EN
        chk("pat.col0", {red, green, blue}, 9'o000);
        while (n < 80 + 3) step();
        chk("pat.col80", {red, green, blue}, 9'o700);
        while (n < 560 + 3) step();
        chk("pat.col560", {red, green, blue}, 9'o777);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion (errors=%0d of %0d checks)", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
